// File: rtl/conv_row_feeder_if.sv
// Handshake bundle between the row feeder and its neighbours: filter/ifmap
// streams in, sliding 3-pixel windows plus weights out to the dot-product stage.
interface conv_row_feeder_if #(
   parameter int INWIDTH = 16
);
   logic               start;
   logic               flt_keep;
   logic [INWIDTH-1:0] flt_data;
   logic               flt_valid;
   logic               flt_ready;
   logic [INWIDTH-1:0] ifm_data;
   logic               ifm_valid;
   logic               ifm_ready;
   logic [INWIDTH-1:0] A0, A1, A2;
   logic [INWIDTH-1:0] B0, B1, B2;
   logic               win_valid;
   logic               win_ready;
   logic               win_last;
   logic               busy;
   logic               done;

   modport master (
      output start, flt_keep, flt_data, flt_valid, ifm_data, ifm_valid, win_ready,
      input  flt_ready, ifm_ready, A0, A1, A2, B0, B1, B2, win_valid, win_last, busy, done
   );

   modport slave (
      input  start, flt_keep, flt_data, flt_valid, ifm_data, ifm_valid, win_ready,
      output flt_ready, ifm_ready, A0, A1, A2, B0, B1, B2, win_valid, win_last, busy, done
   );
endinterface

// File: rtl/conv_row_feeder.sv
// Operand feeder for the 3-tap dot-product stage: loads a filter row, then
// streams sliding 3-pixel ifmap windows with the weights over valid/ready.
//
// state    | meaning
// IDLE     | waiting for start
// LOAD_FLT | accepting weights w0..w2
// FILL     | preloading x0, x1 into the window shift register
// STREAM   | one window per accepted pixel
// DRAIN    | holding the last window until accepted
// DONE     | one-cycle done pulse
module conv_row_feeder #(
   parameter int INWIDTH = 16,
   parameter int ROW_LEN = 16,
   parameter int CNT_W   = 8
) (
   input logic              clk,
   input logic              rst_n,
   conv_row_feeder_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD_FLT, FILL, STREAM, DRAIN, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(ROW_LEN - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [INWIDTH-1:0] w0_q, w1_q, w2_q, w0_d, w1_d, w2_d;
   logic [INWIDTH-1:0] a0_q, a1_q, a2_q, a0_d, a1_d, a2_d;
   logic [INWIDTH-1:0] b0_q, b1_q, b2_q, b0_d, b1_d, b2_d;
   logic               win_valid_q, win_valid_d;
   logic               win_last_q, win_last_d;
   logic               flt_ready_q, flt_ready_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               ifm_ready;
   logic               flt_fire, ifm_fire, win_fire;

   // ifm_ready must follow win_ready in the same cycle to sustain one window per clock
   always_comb begin
      ifm_ready = 1'b0;
      case (state_q)
         FILL:    ifm_ready = 1'b1;
         STREAM:  ifm_ready = !win_valid_q || bus.win_ready;
         default: ifm_ready = 1'b0;
      endcase
   end

   assign flt_fire = flt_ready_q && bus.flt_valid;
   assign ifm_fire = ifm_ready && bus.ifm_valid;
   assign win_fire = win_valid_q && bus.win_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      w0_d        = w0_q;
      w1_d        = w1_q;
      w2_d        = w2_q;
      a0_d        = a0_q;
      a1_d        = a1_q;
      a2_d        = a2_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      b2_d        = b2_q;
      win_valid_d = win_valid_q;
      win_last_d  = win_last_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cnt_d = '0;
               if (bus.flt_keep) begin
                  state_d = FILL;
                  b0_d    = w0_q;
                  b1_d    = w1_q;
                  b2_d    = w2_q;
               end else begin
                  state_d = LOAD_FLT;
               end
            end
         end
         LOAD_FLT: begin
            if (flt_fire) begin
               cnt_d = cnt_q + ONE;
               if (cnt_q == '0)      w0_d = bus.flt_data;
               else if (cnt_q == ONE) w1_d = bus.flt_data;
               else                  w2_d = bus.flt_data;
               if (cnt_q == TWO) begin
                  // third weight is still on the bus, so B2 takes it directly
                  state_d = FILL;
                  cnt_d   = '0;
                  b0_d    = w0_q;
                  b1_d    = w1_q;
                  b2_d    = bus.flt_data;
               end
            end
         end
         FILL: begin
            if (ifm_fire) begin
               a0_d  = a1_q;
               a1_d  = a2_q;
               a2_d  = bus.ifm_data;
               cnt_d = cnt_q + ONE;
               if (cnt_q == ONE) state_d = STREAM;
            end
         end
         STREAM: begin
            if (ifm_fire) begin
               a0_d        = a1_q;
               a1_d        = a2_q;
               a2_d        = bus.ifm_data;
               cnt_d       = cnt_q + ONE;
               win_valid_d = 1'b1;
               if (cnt_q == LAST_PIX) begin
                  win_last_d = 1'b1;
                  state_d    = DRAIN;
               end
            end else if (win_fire) begin
               win_valid_d = 1'b0;
            end
         end
         DRAIN: begin
            if (win_fire) begin
               win_valid_d = 1'b0;
               win_last_d  = 1'b0;
               state_d     = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      flt_ready_d = (state_d == LOAD_FLT);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         w0_q        <= '0;
         w1_q        <= '0;
         w2_q        <= '0;
         a0_q        <= '0;
         a1_q        <= '0;
         a2_q        <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         b2_q        <= '0;
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
         flt_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         w0_q        <= w0_d;
         w1_q        <= w1_d;
         w2_q        <= w2_d;
         a0_q        <= a0_d;
         a1_q        <= a1_d;
         a2_q        <= a2_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         b2_q        <= b2_d;
         win_valid_q <= win_valid_d;
         win_last_q  <= win_last_d;
         flt_ready_q <= flt_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.flt_ready = flt_ready_q;
   assign bus.ifm_ready = ifm_ready;
   assign bus.A0        = a0_q;
   assign bus.A1        = a1_q;
   assign bus.A2        = a2_q;
   assign bus.B0        = b0_q;
   assign bus.B1        = b1_q;
   assign bus.B2        = b2_q;
   assign bus.win_valid = win_valid_q;
   assign bus.win_last  = win_last_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule
